mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage directly downstream of the MEM stage.
- Registers the MEM results (load data, ALU/SLT mux result, destination register, write-back controls) and drives the register-file write port.
- Tolerates a data memory with variable load latency: it holds the pipeline with a stall until the load response arrives, and aborts the load on timeout.
- Also provides a forwarding source for the EX stage.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register index width.
- TIMEOUT, 15, maximum cycles spent waiting for a load response before abort (≥1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  the instruction currently in MEM is valid.
- i_RegWrite  input  1  instruction writes the register file.
- i_MemtoReg  input  1  1 = write back load data, 0 = write back ALU/SLT mux result.
- i_MemRead  input  1  instruction is a load.
- i_rd  input  REG_AW  destination register.
- i_ReadData  input  DATA_W  load data from data memory.
- i_Mux  input  DATA_W  ALU/SLT result from the MEM stage.
- i_mem_ready  input  1  data memory has valid i_ReadData this cycle.
- o_stall  output  1  freeze IF/ID/EX/MEM this cycle (combinational).
- o_wb_valid  output  1  WB register holds a valid instruction.
- o_RegWrite  output  1  register-file write enable.
- o_rd  output  REG_AW  register-file write index.
- o_WriteData  output  DATA_W  register-file write data.
- o_mem_err  output  1  one-cycle pulse: load timed out.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, counter=0.
  - o_wb_valid=0, o_RegWrite=0, o_rd=0, o_WriteData=0, o_mem_err=0.
  - o_stall=0 while in reset.
- FSM states:
  - IDLE: accepts a new instruction every cycle.
  - WAIT_LD: a load is outstanding.
- IDLE behaviour:
  - i_valid=0: next cycle WB register holds a bubble (o_wb_valid=0, o_RegWrite=0; o_rd and o_WriteData keep their old values).
  - i_valid=1 and (i_MemRead=0 or i_mem_ready=1): capture next edge. o_WriteData = i_MemtoReg ? i_ReadData : i_Mux; o_rd=i_rd; o_wb_valid=1; o_RegWrite = i_RegWrite & (i_rd != 0).
  - Latency is exactly 1 cycle.
  - i_valid=1, i_MemRead=1, i_mem_ready=0: o_stall=1 combinationally this cycle. Next state WAIT_LD, counter=1, WB register receives a bubble.
- WAIT_LD behaviour:
  - The upstream stage is frozen, so the i_* inputs are held stable.
  - i_mem_ready=1: o_stall=0; capture as in IDLE; next state IDLE; counter=0.
  - i_mem_ready=0 and counter<TIMEOUT: o_stall=1; counter+1; bubble.
  - i_mem_ready=0 and counter==TIMEOUT: o_stall=0. Instruction is dropped (bubble, no register write). o_mem_err=1 for the next cycle only. Next state IDLE; counter=0.
- Counter:
  - Unsigned, width $clog2(TIMEOUT+1).
  - Never wraps; it saturates at TIMEOUT by construction.
- x0 writes: o_RegWrite is never 1 with o_rd=0, regardless of the value of i_RegWrite.
- i_mem_ready while i_MemRead=0: ignored.
- i_valid drops while in WAIT_LD: this is not legal upstream behaviour, because the upstream stage is stalled. If it happens, the instruction is treated as a bubble: return to IDLE, no write, no error.
- Reset asserted in WAIT_LD: immediate return to IDLE. No o_mem_err and no write.
- o_mem_err and o_wb_valid are never 1 in the same cycle.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and REG_AW constants.
  - typedef wb_state_t {IDLE, WAIT_LD}.
  - typedef wb_bundle_t {valid, regwrite, rd, data}; reused by the forwarding unit.
- One sub-module, wb_timeout_ctr: saturating counter with clear/enable/at_limit, parameterised on TIMEOUT.
- Write-back mux and WB register stay inline.

Test Plan:
- Reset then ALU op (i_valid=1, i_MemtoReg=0, i_Mux=0x0000_002A, i_rd=5, i_RegWrite=1) -> 1 cycle later: o_wb_valid=1, o_RegWrite=1, o_rd=5, o_WriteData=0x2A; o_stall=0 throughout.
- Write to x0 (i_rd=0, i_RegWrite=1, i_Mux=0xFFFF_FFFF) -> o_wb_valid=1, o_RegWrite=0.
- Load, ready same cycle (i_MemRead=1, i_MemtoReg=1, i_ReadData=0xDEAD_BEEF, i_rd=7, i_mem_ready=1) -> next cycle: o_WriteData=0xDEADBEEF, o_rd=7, o_RegWrite=1; no stall.
- Load, ready after 3 cycles -> o_stall=1 for cycles 0-2, 0 on cycle 3. Writeback of i_ReadData visible on cycle 4; o_wb_valid=0 on cycles 1-3.
- Load never ready, TIMEOUT=15 -> o_stall=1 for 15 cycles, then 0. o_mem_err=1 for exactly one cycle; o_RegWrite=0 throughout; FSM back in IDLE and accepting an ALU op next cycle.
- i_rst_n pulled low for 1 cycle while in WAIT_LD at counter=4 -> all outputs 0 immediately. After release: o_stall=0 and no o_mem_err.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, MEM/WB state encoding
// and the write-back bundle also consumed by the forwarding unit.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating load-wait counter; clear has priority over enable.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_at_limit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_at_limit = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with variable-latency load handling,
// stall generation and load-timeout abort.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_AW  = cpu_pkg::REG_AW,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_RegWrite,
    input  logic              i_MemtoReg,
    input  logic              i_MemRead,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [DATA_W-1:0] i_ReadData,
    input  logic [DATA_W-1:0] i_Mux,
    input  logic              i_mem_ready,
    output logic              o_stall,
    output logic              o_wb_valid,
    output logic              o_RegWrite,
    output logic [REG_AW-1:0] o_rd,
    output logic [DATA_W-1:0] o_WriteData,
    output logic              o_mem_err
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    wb_bundle_t        r_wb;
    logic              r_mem_err;
    logic              w_capture;
    logic              w_timeout;
    logic              w_stall;
    logic              w_at_limit;
    logic [DATA_W-1:0] w_wb_data;

    assign w_wb_data = i_MemtoReg ? i_ReadData : i_Mux;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_stall     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_valid && i_MemRead && !i_mem_ready) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WAIT_LD;
                end else if (i_valid) begin
                    w_capture = 1'b1;
                end
            end
            WAIT_LD: begin
                // A dropped i_valid here is illegal upstream; treat as bubble.
                if (!i_valid) begin
                    w_state_nxt = IDLE;
                end else if (i_mem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_at_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_stall = w_stall & i_rst_n;

    // Counter tracks consecutive stall cycles of the current load.
    wb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_ctr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (!w_stall),
        .i_en      (w_stall),
        .o_at_limit(w_at_limit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb      <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_wb.valid    <= w_capture;
            r_wb.regwrite <= w_capture & i_RegWrite & (i_rd != '0);
            if (w_capture) begin
                r_wb.rd   <= i_rd;
                r_wb.data <= w_wb_data;
            end
            r_mem_err <= w_timeout;
        end
    end

    assign o_wb_valid  = r_wb.valid;
    assign o_RegWrite  = r_wb.regwrite;
    assign o_rd        = r_wb.rd;
    assign o_WriteData = r_wb.data;
    assign o_mem_err   = r_mem_err;

endmodule
